// File: rtl/udp_iq_depacketizer_if.sv
// Byte-stream receive bus from the MAC plus the sample FIFO write port.
// The master side drives the RX bytes and the FIFO full flag.
// The slave side (the depacketizer) consumes bytes and writes samples.
interface udp_iq_depacketizer_if;
  logic [7:0]  rx_data;
  logic        rx_dval;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_err;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_full;

  modport master (
    output rx_data, rx_dval, rx_sop, rx_eop, rx_err, wr_full,
    input  wr_en, wr_data
  );

  modport slave (
    input  rx_data, rx_dval, rx_sop, rx_eop, rx_err, wr_full,
    output wr_en, wr_data
  );
endinterface

// File: rtl/udp_iq_depacketizer.sv
// Receive-side Ethernet/IPv4/UDP depacketizer for the SDR link.
// Frames are filtered on MAC/IP/port. The 64-bit sequence number is
// extracted and the payload is unpacked into {I,Q} sample words for the DAC FIFO.
module udp_iq_depacketizer #(
  parameter logic [47:0] LOCAL_MAC       = 48'h021234567890,
  parameter logic [31:0] LOCAL_IP        = {8'd192, 8'd168, 8'd50, 8'd50},
  parameter logic [15:0] LOCAL_PORT      = 16'd32179,
  parameter bit          ACCEPT_BCAST    = 1'b1,
  parameter int          PAYLOAD_SAMPLES = 366
) (
  input  logic                  clk,
  input  logic                  rst,
  udp_iq_depacketizer_if.slave  bus,
  output logic [63:0]           seq_num,
  output logic                  seq_valid,
  output logic                  seq_gap,
  output logic [31:0]           frame_ok_cnt,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           ovf_cnt
);

  // Index of the final payload byte; a frame is full length once this byte is seen.
  localparam logic [15:0] LAST_IDX = 16'(50 + 4 * PAYLOAD_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEQ,
    S_PAYLOAD,
    S_TAIL,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic [63:0] seq_sh_q, seq_sh_d;
  logic        ucast_q, ucast_d;
  logic        bcast_q, bcast_d;
  logic        first_q, first_d;
  logic [63:0] seq_num_q, seq_num_d;
  logic        seq_valid_q, seq_valid_d;
  logic        seq_gap_q, seq_gap_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] frame_ok_q, frame_ok_d;
  logic [15:0] drop_q, drop_d;
  logic [15:0] ovf_q, ovf_d;

  logic        hdr_ok;
  logic [1:0]  drop_inc;
  logic        ok_inc;
  logic        ovf_inc;
  logic [16:0] drop_sum;
  logic [7:0]  b;

  assign b = bus.rx_data;

  // Destination MAC byte expected at frame byte i (network order).
  function automatic logic [7:0] mac_byte(input logic [2:0] i);
    case (i)
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      3'd5:    mac_byte = LOCAL_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
  endfunction

  // Fixed header fields past the MAC; unlisted bytes are don't-care.
  function automatic logic fixed_byte_ok(input logic [15:0] i, input logic [7:0] v);
    case (i)
      16'd12:  fixed_byte_ok = (v == 8'h08);
      16'd13:  fixed_byte_ok = (v == 8'h00);
      16'd14:  fixed_byte_ok = (v == 8'h45);
      16'd23:  fixed_byte_ok = (v == 8'h11);
      16'd30:  fixed_byte_ok = (v == LOCAL_IP[31:24]);
      16'd31:  fixed_byte_ok = (v == LOCAL_IP[23:16]);
      16'd32:  fixed_byte_ok = (v == LOCAL_IP[15:8]);
      16'd33:  fixed_byte_ok = (v == LOCAL_IP[7:0]);
      16'd36:  fixed_byte_ok = (v == LOCAL_PORT[15:8]);
      16'd37:  fixed_byte_ok = (v == LOCAL_PORT[7:0]);
      default: fixed_byte_ok = 1'b1;
    endcase
  endfunction

  // Per-byte parse: state walk, header filter, seq capture, sample packing.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    word_d      = word_q;
    seq_sh_d    = seq_sh_q;
    ucast_d     = ucast_q;
    bcast_d     = bcast_q;
    first_d     = first_q;
    seq_num_d   = seq_num_q;
    seq_valid_d = 1'b0;
    seq_gap_d   = 1'b0;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    hdr_ok      = 1'b1;
    drop_inc    = 2'd0;
    ok_inc      = 1'b0;
    ovf_inc     = 1'b0;

    if (bus.rx_dval) begin
      if (bus.rx_sop) begin
        // A new frame always wins; an unfinished one is counted as dropped.
        if (state_q inside {S_HDR, S_SEQ, S_PAYLOAD, S_TAIL}) begin
          drop_inc = drop_inc + 2'd1;
        end
        ucast_d = (b == mac_byte(3'd0));
        bcast_d = ACCEPT_BCAST && (b == 8'hFF);
        idx_d   = 16'd1;
        if (bus.rx_eop) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = S_IDLE;
          idx_d    = 16'd0;
        end else if (!ucast_d && !bcast_d) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = S_DROP;
        end else begin
          state_d = S_HDR;
        end
      end else begin
        case (state_q)
          S_HDR: begin
            idx_d = idx_q + 16'd1;
            if (idx_q < 16'd6) begin
              ucast_d = ucast_q && (b == mac_byte(idx_q[2:0]));
              bcast_d = bcast_q && (b == 8'hFF);
              hdr_ok  = ucast_d || bcast_d;
            end else begin
              hdr_ok = fixed_byte_ok(idx_q, b);
            end
            if (bus.rx_eop) begin
              drop_inc = 2'd1;
              state_d  = S_IDLE;
            end else if (!hdr_ok) begin
              drop_inc = 2'd1;
              state_d  = S_DROP;
            end else if (idx_q == 16'd41) begin
              state_d = S_SEQ;
            end
          end
          S_SEQ: begin
            // Little-endian: shift right so byte 42 ends up in bits [7:0].
            seq_sh_d = {b, seq_sh_q[63:8]};
            idx_d    = idx_q + 16'd1;
            if (idx_q == 16'd49) begin
              seq_num_d   = seq_sh_d;
              seq_valid_d = 1'b1;
              seq_gap_d   = !first_q && (seq_sh_d != seq_num_q + 64'd1);
              first_d     = 1'b0;
              lane_d      = 2'd0;
              state_d     = S_PAYLOAD;
            end
            if (bus.rx_eop) begin
              drop_inc = 2'd1;
              state_d  = S_IDLE;
            end
          end
          S_PAYLOAD: begin
            idx_d  = idx_q + 16'd1;
            lane_d = lane_q + 2'd1;
            case (lane_q)
              2'd0:    word_d[23:16] = b;
              2'd1:    word_d[31:24] = b;
              2'd2:    word_d[7:0]   = b;
              default: ;
            endcase
            // Q high byte completes the word; full FIFO at this point loses it.
            if (lane_q == 2'd3) begin
              if (!bus.wr_full) begin
                wr_en_d   = 1'b1;
                wr_data_d = {word_q[31:16], b, word_q[7:0]};
              end else begin
                ovf_inc = 1'b1;
              end
            end
            if (bus.rx_eop) begin
              state_d = S_IDLE;
              if ((idx_q == LAST_IDX) && !bus.rx_err) begin
                ok_inc = 1'b1;
              end else begin
                drop_inc = 2'd1;
              end
            end else if (idx_q == LAST_IDX) begin
              state_d = S_TAIL;
            end
          end
          S_TAIL: begin
            if (bus.rx_eop) begin
              state_d = S_IDLE;
              if (bus.rx_err) begin
                drop_inc = 2'd1;
              end else begin
                ok_inc = 1'b1;
              end
            end
          end
          S_DROP: begin
            if (bus.rx_eop) begin
              state_d = S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Statistics: good frames wrap, drop and overflow counts stick at all-ones.
  always_comb begin
    frame_ok_d = frame_ok_q + {31'd0, ok_inc};
    drop_sum   = {1'b0, drop_q} + {15'd0, drop_inc};
    drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ovf_d      = (ovf_q == 16'hFFFF) ? ovf_q : ovf_q + {15'd0, ovf_inc};
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 16'd0;
      lane_q      <= 2'd0;
      word_q      <= 32'd0;
      seq_sh_q    <= 64'd0;
      ucast_q     <= 1'b0;
      bcast_q     <= 1'b0;
      first_q     <= 1'b1;
      seq_num_q   <= 64'd0;
      seq_valid_q <= 1'b0;
      seq_gap_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 32'd0;
      frame_ok_q  <= 32'd0;
      drop_q      <= 16'd0;
      ovf_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      seq_sh_q    <= seq_sh_d;
      ucast_q     <= ucast_d;
      bcast_q     <= bcast_d;
      first_q     <= first_d;
      seq_num_q   <= seq_num_d;
      seq_valid_q <= seq_valid_d;
      seq_gap_q   <= seq_gap_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      frame_ok_q  <= frame_ok_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign seq_num       = seq_num_q;
  assign seq_valid     = seq_valid_q;
  assign seq_gap       = seq_gap_q;
  assign frame_ok_cnt  = frame_ok_q;
  assign drop_cnt      = drop_q;
  assign ovf_cnt       = ovf_q;

endmodule

// File: tb/tb_udp_iq_depacketizer.sv
// Bench for udp_iq_depacketizer: directed frame table, hand-written corner
// sequences, then randomized frames checked against a frame-level model.
module tb_udp_iq_depacketizer;
  localparam logic [47:0] MAC    = 48'h021234567890;
  localparam logic [31:0] IP     = {8'd192, 8'd168, 8'd50, 8'd50};
  localparam logic [15:0] PORT   = 16'd32179;
  localparam int          NS     = 366;
  localparam int          FLEN   = 50 + 4 * NS;
  localparam int          MAXLEN = 1600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  udp_iq_depacketizer_if bus();
  logic [63:0] seq_num;
  logic        seq_valid;
  logic        seq_gap;
  logic [31:0] frame_ok_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] ovf_cnt;

  udp_iq_depacketizer #(
    .LOCAL_MAC(MAC), .LOCAL_IP(IP), .LOCAL_PORT(PORT),
    .ACCEPT_BCAST(1'b1), .PAYLOAD_SAMPLES(NS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .seq_num(seq_num), .seq_valid(seq_valid), .seq_gap(seq_gap),
    .frame_ok_cnt(frame_ok_cnt), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: record every write and every sequence event, away from the edge.
  logic [31:0] got_q[$];
  int seqv_n = 0, gap_n = 0, stray_gap_n = 0;
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) got_q.push_back(bus.wr_data);
    if (seq_valid === 1'b1) begin
      seqv_n++;
      if (seq_gap === 1'b1) gap_n++;
    end else if (seq_gap === 1'b1) begin
      stray_gap_n++;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    seqv_n = 0;
    gap_n  = 0;
  endtask

  logic [7:0] frm[MAXLEN];
  bit         full_arr[MAXLEN];

  // Good frame to this station; sample k is I=k, Q=0x8000+k unless randomized.
  function automatic void build_frame(input logic [63:0] seq, input bit bcast, input bit rand_pl);
    logic [47:0] m;
    logic [31:0] ip;
    logic [15:0] iv, qv;
    m  = MAC;
    ip = IP;
    for (int i = 0; i < MAXLEN; i++) begin
      frm[i]      = 8'($urandom);
      full_arr[i] = 1'b0;
    end
    for (int i = 0; i < 6; i++) frm[i] = bcast ? 8'hFF : m[47 - 8 * i -: 8];
    frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45; frm[23] = 8'h11;
    for (int i = 0; i < 4; i++) frm[30 + i] = ip[31 - 8 * i -: 8];
    frm[36] = PORT[15:8];
    frm[37] = PORT[7:0];
    for (int i = 0; i < 8; i++) frm[42 + i] = seq[8 * i +: 8];
    for (int k = 0; k < NS; k++) begin
      iv = rand_pl ? 16'($urandom) : 16'(k);
      qv = rand_pl ? 16'($urandom) : 16'(32'h8000 + k);
      frm[50 + 4 * k]     = iv[7:0];
      frm[50 + 4 * k + 1] = iv[15:8];
      frm[50 + 4 * k + 2] = qv[7:0];
      frm[50 + 4 * k + 3] = qv[15:8];
    end
  endfunction

  task automatic idle_bus();
    bus.rx_dval = 1'b0; bus.rx_sop = 1'b0; bus.rx_eop = 1'b0;
    bus.rx_err  = 1'b0; bus.rx_data = 8'h00; bus.wr_full = 1'b0;
  endtask

  task automatic do_reset();
    idle_bus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Stream frm[0..len-1]; optional idle gaps carry junk that must be ignored.
  task automatic send_frame(input int len, input bit err, input bit with_eop,
                            input int rst_at, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 7) == 0) begin
          bus.rx_dval = 1'b0;
          bus.rx_data = 8'($urandom);
          bus.rx_sop  = 1'($urandom_range(0, 1));
          bus.rx_eop  = 1'($urandom_range(0, 1));
          bus.rx_err  = 1'($urandom_range(0, 1));
          bus.wr_full = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      bus.rx_dval = 1'b1;
      bus.rx_data = frm[i];
      bus.rx_sop  = (i == 0);
      bus.rx_eop  = with_eop && (i == len - 1);
      bus.rx_err  = (with_eop && (i == len - 1)) ? err : (gaps ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.wr_full = full_arr[i];
      rst         = (i == rst_at);
      @(posedge clk); #1;
    end
    idle_bus();
    rst = 1'b0;
  endtask

  typedef struct {
    bit          do_rst;
    logic [63:0] seq;
    int          patch_idx;
    logic [7:0]  patch_val;
    int          len;
    bit          err;
    int          full_lo;
    int          full_hi;
    int          rst_at;
    int          exp_nwr;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_ok;
    int          exp_drop;
    int          exp_ovf;
    int          exp_seqv;
    int          exp_gap;
    logic [63:0] exp_seq;
  } vec_t;

  localparam int NV = 12;
  vec_t vt[NV];

  // Higher-level frame model state for the randomized phase.
  int          m_ok, m_drop, m_ovf;
  bit          m_first;
  logic [63:0] m_seq;
  logic [31:0] exp_q[$];

  function automatic bit hdr_matches();
    logic [47:0] d;
    logic [31:0] ipv;
    logic [15:0] pv;
    d = '0;
    for (int i = 0; i < 6; i++) d = {d[39:0], frm[i]};
    ipv = {frm[30], frm[31], frm[32], frm[33]};
    pv  = {frm[36], frm[37]};
    return (d == MAC || d == 48'hFFFFFFFFFFFF) && frm[12] == 8'h08 && frm[13] == 8'h00 &&
           frm[14] == 8'h45 && frm[23] == 8'h11 && ipv == IP && pv == PORT;
  endfunction

  initial begin
    int pl[12];
    rst = 1'b1;
    idle_bus();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_wr_en", 64'(bus.wr_en), 64'd0);
    check("reset_seq_num", seq_num, 64'd0);
    check("reset_seq_valid", 64'(seq_valid), 64'd0);
    check("reset_ok_cnt", 64'(frame_ok_cnt), 64'd0);
    check("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    check("reset_ovf_cnt", 64'(ovf_cnt), 64'd0);

    // rst seq patch val len err flo fhi rst_at | nwr first last ok drop ovf seqv gap seq
    vt[0]  = '{1, 64'd5,   -1, 8'h00, FLEN,    0, -1, -1, -1,  366, 32'h00008000, 32'h016D816D, 1, 0, 0, 1, 0, 64'd5};
    vt[1]  = '{0, 64'd6,   -1, 8'h00, FLEN,    0, -1, -1, -1,  366, 32'h00008000, 32'h016D816D, 2, 0, 0, 1, 0, 64'd6};
    vt[2]  = '{0, 64'd8,   -1, 8'h00, FLEN,    0, -1, -1, -1,  366, 32'h00008000, 32'h016D816D, 3, 0, 0, 1, 1, 64'd8};
    vt[3]  = '{1, 64'd9,   37, 8'hB4, FLEN,    0, -1, -1, -1,    0, 32'h0,        32'h0,        0, 1, 0, 0, 0, 64'd0};
    vt[4]  = '{0, 64'd10,  23, 8'h06, FLEN,    0, -1, -1, -1,    0, 32'h0,        32'h0,        0, 2, 0, 0, 0, 64'd0};
    vt[5]  = '{1, 64'd5,   -1, 8'h00, FLEN,    0, 50, 57, -1,  364, 32'h00028002, 32'h016D816D, 1, 0, 2, 1, 0, 64'd5};
    vt[6]  = '{1, 64'd5,   -1, 8'h00, 1001,    0, -1, -1, -1,  237, 32'h00008000, 32'h00EC80EC, 0, 1, 0, 1, 0, 64'd5};
    vt[7]  = '{0, 64'd6,   -1, 8'h00, FLEN,    0, -1, -1, -1,  366, 32'h00008000, 32'h016D816D, 1, 1, 0, 1, 0, 64'd6};
    vt[8]  = '{1, 64'd100, -1, 8'h00, FLEN,    0, -1, -1, 600, 137, 32'h00008000, 32'h00888088, 0, 0, 0, 1, 0, 64'd0};
    vt[9]  = '{0, 64'd200, -1, 8'h00, FLEN,    0, -1, -1, -1,  366, 32'h00008000, 32'h016D816D, 1, 0, 0, 1, 0, 64'd200};
    vt[10] = '{0, 64'd201, -1, 8'h00, FLEN,    1, -1, -1, -1,  366, 32'h00008000, 32'h016D816D, 1, 1, 0, 1, 0, 64'd201};
    vt[11] = '{0, 64'd202, -1, 8'h00, FLEN+16, 0, -1, -1, -1,  366, 32'h00008000, 32'h016D816D, 2, 1, 0, 1, 0, 64'd202};

    for (int v = 0; v < NV; v++) begin
      if (vt[v].do_rst) do_reset();
      build_frame(vt[v].seq, 1'b0, 1'b0);
      if (vt[v].patch_idx >= 0) frm[vt[v].patch_idx] = vt[v].patch_val;
      if (vt[v].full_lo >= 0)
        for (int i = vt[v].full_lo; i <= vt[v].full_hi; i++) full_arr[i] = 1'b1;
      clear_mon();
      send_frame(vt[v].len, vt[v].err, 1'b1, vt[v].rst_at, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_nwr", v), 64'(got_q.size()), 64'(vt[v].exp_nwr));
      if (vt[v].exp_nwr > 0 && got_q.size() > 0) begin
        check($sformatf("v%0d_first", v), 64'(got_q[0]), 64'(vt[v].exp_first));
        check($sformatf("v%0d_last", v), 64'(got_q[got_q.size() - 1]), 64'(vt[v].exp_last));
      end
      check($sformatf("v%0d_ok_cnt", v), 64'(frame_ok_cnt), 64'(vt[v].exp_ok));
      check($sformatf("v%0d_drop_cnt", v), 64'(drop_cnt), 64'(vt[v].exp_drop));
      check($sformatf("v%0d_ovf_cnt", v), 64'(ovf_cnt), 64'(vt[v].exp_ovf));
      check($sformatf("v%0d_seq_valid", v), 64'(seqv_n), 64'(vt[v].exp_seqv));
      check($sformatf("v%0d_seq_gap", v), 64'(gap_n), 64'(vt[v].exp_gap));
      check($sformatf("v%0d_seq_num", v), seq_num, vt[v].exp_seq);
    end

    // rx_sop mid-frame aborts the first frame; the new one is parsed normally.
    do_reset();
    clear_mon();
    build_frame(64'd1, 1'b0, 1'b0);
    send_frame(300, 1'b0, 1'b0, -1, 1'b0);
    build_frame(64'd2, 1'b0, 1'b0);
    send_frame(FLEN, 1'b0, 1'b1, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_nwr", 64'(got_q.size()), 64'd428);
    check("abort_drop_cnt", 64'(drop_cnt), 64'd1);
    check("abort_ok_cnt", 64'(frame_ok_cnt), 64'd1);
    check("abort_seq_valid", 64'(seqv_n), 64'd2);
    check("abort_seq_gap", 64'(gap_n), 64'd0);

    // Single-byte frame (sop and eop together) is a drop.
    clear_mon();
    build_frame(64'd3, 1'b0, 1'b0);
    send_frame(1, 1'b0, 1'b1, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("onebyte_drop_cnt", 64'(drop_cnt), 64'd2);
    check("onebyte_nwr", 64'(got_q.size()), 64'd0);
    check("onebyte_seq_valid", 64'(seqv_n), 64'd0);

    // Randomized frames against the frame-level model.
    do_reset();
    m_ok = 0; m_drop = 0; m_ovf = 0; m_first = 1'b1; m_seq = 64'd0;
    pl = '{0, 2, 3, 5, 12, 13, 14, 23, 30, 33, 36, 37};
    for (int f = 0; f < 16; f++) begin
      logic [63:0] s;
      logic [63:0] s_new;
      int          len, r, bad, e_seqv, e_gap;
      bit          err, hok;
      s = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : m_seq + 64'd1;
      build_frame(s, $urandom_range(0, 4) == 0, 1'b1);
      if ($urandom_range(0, 4) == 0)
        frm[pl[$urandom_range(0, 11)]] ^= 8'(1 << $urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r < 6) len = FLEN;
      else if (r < 8) len = FLEN + $urandom_range(1, 20);
      else len = $urandom_range(1, FLEN - 1);
      err = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < MAXLEN; i++) full_arr[i] = ($urandom_range(0, 9) == 0);

      exp_q.delete();
      e_seqv = 0;
      e_gap  = 0;
      hok = hdr_matches();
      if (hok && len >= 50) begin
        s_new = {frm[49], frm[48], frm[47], frm[46], frm[45], frm[44], frm[43], frm[42]};
        e_seqv = 1;
        e_gap  = (!m_first && s_new != m_seq + 64'd1) ? 1 : 0;
        m_seq   = s_new;
        m_first = 1'b0;
      end
      if (hok) begin
        for (int k = 0; k < NS; k++) begin
          int a;
          a = 50 + 4 * k;
          if (a + 3 < len) begin
            if (full_arr[a + 3]) m_ovf++;
            else exp_q.push_back({frm[a + 1], frm[a], frm[a + 3], frm[a + 2]});
          end
        end
      end
      if (hok && len >= FLEN && !err) m_ok++;
      else m_drop++;

      clear_mon();
      send_frame(len, err, 1'b1, -1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("r%0d_nwr", f), 64'(got_q.size()), 64'(exp_q.size()));
      bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0)
        check($sformatf("r%0d_word%0d", f, bad), 64'(got_q[bad]), 64'(exp_q[bad]));
      else if (got_q.size() > 0 && exp_q.size() > 0)
        check($sformatf("r%0d_lastword", f), 64'(got_q[got_q.size() - 1]), 64'(exp_q[exp_q.size() - 1]));
      check($sformatf("r%0d_seq_valid", f), 64'(seqv_n), 64'(e_seqv));
      check($sformatf("r%0d_seq_gap", f), 64'(gap_n), 64'(e_gap));
      check($sformatf("r%0d_seq_num", f), seq_num, m_seq);
      check($sformatf("r%0d_ok_cnt", f), 64'(frame_ok_cnt), 64'(m_ok));
      check($sformatf("r%0d_drop_cnt", f), 64'(drop_cnt), 64'(m_drop));
      check($sformatf("r%0d_ovf_cnt", f), 64'(ovf_cnt), 64'(m_ovf));
    end
    check("stray_seq_gap", 64'(stray_gap_n), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
